// File: rtl/sram_boot_config_pkg.sv
// Shared state encodings and default configuration address for the SRAM boot loader.
package sram_boot_config_pkg;

  localparam int         STATE_W = 2;
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [20:0] DEFAULT_BASE_ADDR = 21'h008FD5;

endpackage

// File: rtl/sram_boot_config.sv
// Boot-time config loader: reads NBYTES from SRAM, holds the core in reset, then hands the SRAM bus to the core.
`default_nettype none
module sram_boot_config
  import sram_boot_config_pkg::*;
#(
  parameter int                ADDR_W    = 21,
  parameter int                CORE_AW   = 19,
  parameter int                NBYTES    = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int                SETTLE    = 2,
  parameter int                HOLD      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reload,
  input  logic [CORE_AW-1:0]    core_addr,
  input  logic                  core_we_n,
  input  logic [7:0]            sram_data_in,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic                  sram_we_n,
  output logic [NBYTES*8-1:0]   cfg,
  output logic                  cfg_valid,
  output logic                  core_reset_n,
  output logic                  busy
);

  localparam int IDX_W  = $clog2(NBYTES + 1);
  localparam int WAIT_W = $clog2(SETTLE + 1);
  localparam int HOLD_W = $clog2(HOLD + 1);

  localparam logic [IDX_W-1:0]  c_last_idx  = IDX_W'(NBYTES - 1);
  localparam logic [WAIT_W-1:0] c_last_wait = WAIT_W'(SETTLE - 1);
  localparam logic [HOLD_W-1:0] c_last_hold = HOLD_W'(HOLD - 1);

  logic [STATE_W-1:0]  state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [NBYTES*8-1:0] cfg_q, cfg_d;
  logic                rel_q, rel_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    hold_d  = hold_q;
    cfg_d   = cfg_q;
    rel_d   = rel_q;
    case (state_q)
      ST_LOAD: begin
        if (wait_q == c_last_wait) begin
          wait_d = '0;
          idx_d  = idx_q + 1'b1;
          for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IDX_W'(i)) cfg_d[8*i +: 8] = sram_data_in;
          end
          if (idx_q == c_last_idx) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_q == c_last_hold) begin
          state_d = ST_RUN;
          rel_d   = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RUN: begin
        // Old cfg bytes stay visible until each is recaptured.
        if (reload) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          wait_d  = '0;
          rel_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_LOAD;
        idx_d   = '0;
        wait_d  = '0;
        rel_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      wait_q  <= '0;
      hold_q  <= '0;
      cfg_q   <= '0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      cfg_q   <= cfg_d;
      rel_q   <= rel_d;
    end
  end

  // Core only gets write access once it owns the bus.
  always_comb begin
    sram_addr = BASE_ADDR;
    sram_we_n = 1'b1;
    case (state_q)
      ST_LOAD: sram_addr = BASE_ADDR + ADDR_W'(idx_q);
      ST_RUN: begin
        sram_addr = ADDR_W'(core_addr);
        sram_we_n = core_we_n;
      end
      default: sram_addr = BASE_ADDR;
    endcase
  end

  assign cfg          = cfg_q;
  assign cfg_valid    = rel_q;
  assign core_reset_n = rel_q;
  assign busy         = (state_q != ST_RUN);

endmodule
`default_nettype wire
